// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: registered bus handshake with pipeline stall,
// AdEL/AdES/bus-error detection and the LL/SC link bit.
module mem_access_unit #(
    parameter int ADDR_W     = 32,
    parameter int TIMEOUT    = 16,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid_i,
    input  logic [3:0]        op_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    input  logic              flush_i,
    input  logic              llclr_i,
    output logic              bus_req_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [31:0]       bus_wdata_o,
    input  logic              bus_ack_i,
    input  logic [31:0]       bus_rdata_i,
    output logic              stallreq_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic [4:0]        excepttype_o,
    output logic [ADDR_W-1:0] badvaddr_o,
    output logic              llbit_o
);
    // state | meaning
    // IDLE  | waiting for a memory op from the MEM stage
    // BUS   | request outstanding, result will be reported
    // DRAIN | flushed mid-access; finish the bus cycle silently
    // RESP  | one-cycle result / exception strobe

    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DRAIN, S_RESP} state_t;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;
    localparam logic [3:0] OP_LL  = 4'd9;
    localparam logic [3:0] OP_SC  = 4'd10;

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = (TIMEOUT > 1) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               TO_EN    = (TIMEOUT != 0);

    state_t           state;
    logic [3:0]       op_q;
    logic [1:0]       lane_q;
    logic             half_hi_q;
    logic [CNT_W-1:0] cnt;

    logic        is_byte, is_half, is_word, is_load, is_store;
    logic        misaligned, accept, timeout_hit, sc_ok;
    logic [1:0]  lane;
    logic        half_hi;
    logic [3:0]  sel_d;
    logic [31:0] wdata_d, shifted, result_d;
    logic [15:0] half_d;

    always_comb begin
        is_byte  = (op_i == OP_LB) || (op_i == OP_LBU) || (op_i == OP_SB);
        is_half  = (op_i == OP_LH) || (op_i == OP_LHU) || (op_i == OP_SH);
        is_word  = (op_i == OP_LW) || (op_i == OP_SW) || (op_i == OP_LL) || (op_i == OP_SC);
        is_store = (op_i == OP_SB) || (op_i == OP_SH) || (op_i == OP_SW) || (op_i == OP_SC);
        is_load  = (is_byte || is_half || is_word) && !is_store;
        // Byte lane holding the addressed byte; big-endian puts offset 0 in the top lane.
        lane     = BIG_ENDIAN ? ~addr_i[1:0] : addr_i[1:0];
        half_hi  = BIG_ENDIAN ? ~addr_i[1] : addr_i[1];
        misaligned = (is_half && addr_i[0]) || (is_word && (addr_i[1:0] != 2'b00));
        sel_d   = 4'b1111;
        wdata_d = wdata_i;
        if (is_byte) begin
            sel_d   = 4'b0001 << lane;
            wdata_d = {4{wdata_i[7:0]}};
        end else if (is_half) begin
            sel_d   = half_hi ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata_i[15:0]}};
        end
    end

    // rst gating keeps stallreq_o low while reset is held with an op pending.
    assign accept = rst && (state == S_IDLE) && op_valid_i && (is_load || is_store) && !flush_i;

    always_comb begin
        shifted  = bus_rdata_i >> {lane_q, 3'b000};
        half_d   = half_hi_q ? bus_rdata_i[31:16] : bus_rdata_i[15:0];
        result_d = 32'd0;
        case (op_q)
            OP_LB:        result_d = {{24{shifted[7]}}, shifted[7:0]};
            OP_LBU:       result_d = {24'd0, shifted[7:0]};
            OP_LH:        result_d = {{16{half_d[15]}}, half_d};
            OP_LHU:       result_d = {16'd0, half_d};
            OP_LW, OP_LL: result_d = bus_rdata_i;
            OP_SC:        result_d = 32'd1;
            default:      result_d = 32'd0;
        endcase
    end

    assign timeout_hit = TO_EN && (cnt == '0);
    assign sc_ok       = (op_q == OP_SC) && (excepttype_o == EXC_NONE) && rdata_o[0];
    assign done_o      = (state == S_RESP) && !flush_i;
    assign stallreq_o  = accept || (state == S_BUS) || (state == S_DRAIN);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            op_q         <= 4'd0;
            lane_q       <= 2'd0;
            half_hi_q    <= 1'b0;
            cnt          <= '0;
            bus_req_o    <= 1'b0;
            bus_we_o     <= 1'b0;
            bus_sel_o    <= 4'd0;
            bus_addr_o   <= '0;
            bus_wdata_o  <= 32'd0;
            rdata_o      <= 32'd0;
            excepttype_o <= EXC_NONE;
            badvaddr_o   <= '0;
            llbit_o      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q      <= op_i;
                        lane_q    <= lane;
                        half_hi_q <= half_hi;
                        if (misaligned) begin
                            state        <= S_RESP;
                            excepttype_o <= is_load ? EXC_ADEL : EXC_ADES;
                            badvaddr_o   <= addr_i;
                            rdata_o      <= 32'd0;
                        end else if ((op_i == OP_SC) && !llbit_o) begin
                            state        <= S_RESP;
                            excepttype_o <= EXC_NONE;
                            rdata_o      <= 32'd0;
                        end else begin
                            state        <= S_BUS;
                            excepttype_o <= EXC_NONE;
                            bus_req_o    <= 1'b1;
                            bus_we_o     <= is_store;
                            bus_sel_o    <= sel_d;
                            bus_addr_o   <= {addr_i[ADDR_W-1:2], 2'b00};
                            bus_wdata_o  <= is_store ? wdata_d : 32'd0;
                            cnt          <= CNT_LOAD;
                        end
                    end
                end
                S_BUS: begin
                    if (bus_ack_i) begin
                        bus_req_o <= 1'b0;
                        rdata_o   <= result_d;
                        state     <= flush_i ? S_IDLE : S_RESP;
                    end else if (timeout_hit) begin
                        bus_req_o    <= 1'b0;
                        excepttype_o <= EXC_DBE;
                        state        <= flush_i ? S_IDLE : S_RESP;
                    end else begin
                        if (cnt != '0) cnt <= cnt - 1'b1;
                        if (flush_i) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (bus_ack_i || timeout_hit) begin
                        bus_req_o <= 1'b0;
                        state     <= S_IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (llclr_i) begin
                llbit_o <= 1'b0;
            end else if ((state == S_RESP) && !flush_i) begin
                if (sc_ok)
                    llbit_o <= 1'b0;
                else if ((op_q == OP_LL) && (excepttype_o == EXC_NONE))
                    llbit_o <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: big- and little-endian instances share stimulus and are
// checked against a cycle-count/arithmetic reference model.
module tb_mem_access_unit;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid_i, flush_i, llclr_i, bus_ack_i;
    logic [3:0]  op_i;
    logic [31:0] addr_i, wdata_i, bus_rdata_i;

    logic        b_req, b_we, b_stall, b_done, b_ll;
    logic [3:0]  b_sel;
    logic [31:0] b_addr, b_wdata, b_rdata, b_bad;
    logic [4:0]  b_exc;
    logic        l_req, l_we, l_stall, l_done, l_ll;
    logic [3:0]  l_sel;
    logic [31:0] l_addr, l_wdata, l_rdata, l_bad;
    logic [4:0]  l_exc;

    int   n_cmp = 0;
    int   n_err = 0;
    logic m_ll  = 1'b0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .llclr_i(llclr_i), .bus_req_o(b_req),
        .bus_we_o(b_we), .bus_sel_o(b_sel), .bus_addr_o(b_addr), .bus_wdata_o(b_wdata),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .stallreq_o(b_stall),
        .done_o(b_done), .rdata_o(b_rdata), .excepttype_o(b_exc), .badvaddr_o(b_bad),
        .llbit_o(b_ll));

    mem_access_unit #(.ADDR_W(32), .TIMEOUT(TO), .BIG_ENDIAN(1'b0)) dut_le (
        .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .flush_i(flush_i), .llclr_i(llclr_i), .bus_req_o(l_req),
        .bus_we_o(l_we), .bus_sel_o(l_sel), .bus_addr_o(l_addr), .bus_wdata_o(l_wdata),
        .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i), .stallreq_o(l_stall),
        .done_o(l_done), .rdata_o(l_rdata), .excepttype_o(l_exc), .badvaddr_o(l_bad),
        .llbit_o(l_ll));

    // Memory byte at offset k sits in lane 3-k (big-endian) or lane k (little-endian).
    function automatic int m_pos(input logic [3:0] op, input logic [1:0] k, input bit be);
        if (op inside {1, 2, 6}) return be ? 3 - int'(k) : int'(k);
        if (op inside {3, 4, 7}) return be ? 2 - int'(k) : int'(k);
        return 0;
    endfunction

    function automatic logic [3:0] m_sel(input logic [3:0] op, input logic [1:0] k, input bit be);
        if (op inside {1, 2, 6}) return 4'd1 << m_pos(op, k, be);
        if (op inside {3, 4, 7}) return 4'd3 << m_pos(op, k, be);
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [3:0] op, input logic [31:0] w);
        if (op == 6) return {4{w[7:0]}};
        if (op == 7) return {2{w[15:0]}};
        return w;
    endfunction

    function automatic logic [31:0] m_load(input logic [3:0] op, input logic [1:0] k,
                                           input logic [31:0] rd, input bit be);
        logic [31:0] s;
        s = rd >> (8 * m_pos(op, k, be));
        case (op)
            1:       return {{24{s[7]}}, s[7:0]};
            2:       return {24'd0, s[7:0]};
            3:       return {{16{s[15]}}, s[15:0]};
            4:       return {16'd0, s[15:0]};
            default: return rd;
        endcase
    endfunction

    // One op from accept to done; op_valid_i is left high so a following call is back-to-back.
    task automatic xact(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input int ack_wait, input logic [31:0] rd);
        logic ld, st, bt, hw, mis, fast, acked;
        int   k;
        logic [4:0] e_exc;
        ld    = op inside {1, 2, 3, 4, 5, 9};
        st    = op inside {6, 7, 8, 10};
        bt    = op inside {1, 2, 6};
        hw    = op inside {3, 4, 7};
        mis   = (hw && addr[0]) || (!bt && !hw && addr[1:0] != 2'b00);
        fast  = mis || (op == 10 && !m_ll);
        acked = ack_wait < TO;
        k     = acked ? ack_wait + 1 : TO;
        @(negedge clk);
        op_valid_i = 1'b1; op_i = op; addr_i = addr; wdata_i = wd; bus_ack_i = 1'b0; bus_rdata_i = rd;
        #1;
        n_cmp++;
        if (b_stall !== 1'b1) begin n_err++; $display("FAIL accept_stall op=%0d got %b want 1", op, b_stall); end
        n_cmp++;
        if (b_ll !== m_ll) begin n_err++; $display("FAIL llbit op=%0d got %b want %b", op, b_ll, m_ll); end
        if (fast) begin
            e_exc = mis ? (ld ? 5'd4 : 5'd5) : 5'd0;
            @(negedge clk); #1;
            n_cmp++;
            if ({b_done, b_stall, b_req} !== 3'b100) begin
                n_err++; $display("FAIL fast_done op=%0d got done/stall/req=%b want 100", op, {b_done, b_stall, b_req});
            end
            n_cmp++;
            if (b_exc !== e_exc) begin n_err++; $display("FAIL fast_exc op=%0d got %0d want %0d", op, b_exc, e_exc); end
            n_cmp++;
            if (mis && b_bad !== addr) begin n_err++; $display("FAIL badvaddr got %h want %h", b_bad, addr); end
            if (!mis && b_rdata !== 32'd0) begin n_err++; $display("FAIL sc_fail_rdata got %h want 0", b_rdata); end
        end else begin
            for (int c = 1; c <= k; c++) begin
                @(negedge clk);
                bus_ack_i = acked && (c == k);
                #1;
                n_cmp++;
                if ({b_req, b_done, b_stall} !== 3'b101) begin
                    n_err++; $display("FAIL bus_phase op=%0d cyc=%0d got req/done/stall=%b want 101", op, c, {b_req, b_done, b_stall});
                end
                if (c == 1) begin
                    n_cmp++;
                    if (b_sel !== m_sel(op, addr[1:0], 1'b1) || l_sel !== m_sel(op, addr[1:0], 1'b0)) begin
                        n_err++; $display("FAIL bus_sel op=%0d addr=%h got be=%b le=%b want be=%b le=%b", op, addr,
                                          b_sel, l_sel, m_sel(op, addr[1:0], 1'b1), m_sel(op, addr[1:0], 1'b0));
                    end
                    n_cmp++;
                    if (b_we !== st || b_addr !== {addr[31:2], 2'b00}) begin
                        n_err++; $display("FAIL bus_we_addr op=%0d got we=%b addr=%h want we=%b addr=%h", op, b_we, b_addr, st, {addr[31:2], 2'b00});
                    end
                    if (st) begin
                        n_cmp++;
                        if (b_wdata !== m_wdata(op, wd) || l_wdata !== m_wdata(op, wd)) begin
                            n_err++; $display("FAIL bus_wdata op=%0d got be=%h le=%h want %h", op, b_wdata, l_wdata, m_wdata(op, wd));
                        end
                    end
                end
            end
            @(negedge clk);
            bus_ack_i = 1'b0;
            #1;
            n_cmp++;
            if ({b_done, b_stall, b_req} !== 3'b100) begin
                n_err++; $display("FAIL resp op=%0d got done/stall/req=%b want 100", op, {b_done, b_stall, b_req});
            end
            n_cmp++;
            if (b_exc !== (acked ? 5'd0 : 5'd7)) begin
                n_err++; $display("FAIL resp_exc op=%0d got %0d want %0d", op, b_exc, acked ? 0 : 7);
            end
            if (acked && ld) begin
                n_cmp++;
                if (b_rdata !== m_load(op, addr[1:0], rd, 1'b1) || l_rdata !== m_load(op, addr[1:0], rd, 1'b0)) begin
                    n_err++; $display("FAIL load_data op=%0d addr=%h got be=%h le=%h want be=%h le=%h", op, addr, b_rdata,
                                      l_rdata, m_load(op, addr[1:0], rd, 1'b1), m_load(op, addr[1:0], rd, 1'b0));
                end
            end
            if (acked && op == 10) begin
                n_cmp++;
                if (b_rdata !== 32'd1) begin n_err++; $display("FAIL sc_ok_rdata got %h want 1", b_rdata); end
            end
            if (acked && op == 9)  m_ll = 1'b1;
            if (acked && op == 10) m_ll = 1'b0;
        end
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        op_valid_i = 1'b0; flush_i = 1'b0; llclr_i = 1'b0; bus_ack_i = 1'b0;
    endtask

    task automatic pulse_llclr();
        @(negedge clk);
        op_valid_i = 1'b0; llclr_i = 1'b1;
        @(negedge clk);
        llclr_i = 1'b0; m_ll = 1'b0;
        #1;
        n_cmp++;
        if (b_ll !== 1'b0) begin n_err++; $display("FAIL llclr got %b want 0", b_ll); end
    endtask

    task automatic test_reset();
        rst = 1'b0; op_valid_i = 1'b0; op_i = 4'd0; addr_i = 32'd0; wdata_i = 32'd0;
        flush_i = 1'b0; llclr_i = 1'b0; bus_ack_i = 1'b0; bus_rdata_i = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if ({b_req, b_we, b_sel, b_addr, b_wdata, b_stall, b_done, b_rdata, b_exc, b_bad, b_ll} !== '0 ||
            {l_req, l_sel, l_stall, l_done, l_ll} !== '0) begin
            n_err++; $display("FAIL reset_outputs got req=%b sel=%b stall=%b done=%b ll=%b want all 0", b_req, b_sel, b_stall, b_done, b_ll);
        end
        @(negedge clk);
        rst = 1'b1;
        m_ll = 1'b0;
    endtask

    task automatic test_lb_be();
        xact(4'd1, 32'h0000_1003, 32'd0, 3, 32'h0000_00F0);
        n_cmp++;
        if (b_rdata !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL lb_1003 got %h want fffffff0", b_rdata); end
        idle_cycle();
    endtask

    task automatic test_store_lanes();
        xact(4'd7, 32'h0000_2002, 32'h1234_ABCD, 0, 32'd0);
        xact(4'd6, 32'h0000_2001, 32'h0000_005A, 1, 32'd0);
        xact(4'd8, 32'h0000_2004, 32'hDEAD_BEEF, 2, 32'd0);
        idle_cycle();
    endtask

    task automatic test_misaligned();
        xact(4'd5, 32'h0000_3001, 32'd0, 0, 32'd0);
        xact(4'd8, 32'h0000_3002, 32'd0, 0, 32'd0);
        xact(4'd3, 32'h0000_3003, 32'd0, 0, 32'd0);
        xact(4'd9, 32'h0000_3006, 32'd0, 0, 32'd0);
        idle_cycle();
    endtask

    task automatic test_llsc();
        xact(4'd9, 32'h0000_4000, 32'd0, 1, 32'h1111_2222);
        xact(4'd10, 32'h0000_4000, 32'h5555_AAAA, 0, 32'd0);
        xact(4'd10, 32'h0000_4000, 32'h5555_AAAA, 0, 32'd0);
        xact(4'd9, 32'h0000_4000, 32'd0, 0, 32'd0);
        pulse_llclr();
        xact(4'd10, 32'h0000_4000, 32'd0, 0, 32'd0);
        idle_cycle();
    endtask

    task automatic test_timeout();
        xact(4'd5, 32'h0000_5000, 32'd0, TO, 32'd0);
        xact(4'd5, 32'h0000_5004, 32'd0, TO - 1, 32'hCAFE_F00D);
        xact(4'd9, 32'h0000_5008, 32'd0, TO, 32'd0);
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        xact(4'd5, 32'h0000_8000, 32'd0, 0, 32'h0102_0304);
        xact(4'd8, 32'h0000_8004, 32'h0A0B_0C0D, 0, 32'd0);
        xact(4'd4, 32'h0000_8002, 32'd0, 0, 32'h8899_AABB);
        idle_cycle();
    endtask

    task automatic test_flush();
        @(negedge clk);
        op_valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h0000_6000; flush_i = 1'b1;
        #1;
        n_cmp++;
        if (b_stall !== 1'b0) begin n_err++; $display("FAIL flush_accept_stall got %b want 0", b_stall); end
        @(negedge clk);
        op_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        n_cmp++;
        if ({b_req, b_done} !== 2'b00) begin n_err++; $display("FAIL flush_accept_req got %b want 00", {b_req, b_done}); end
        pulse_llclr();
        @(negedge clk);
        op_valid_i = 1'b1; op_i = 4'd9; addr_i = 32'h0000_6100;
        @(negedge clk);
        flush_i = 1'b1; op_valid_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++;
            if ({b_req, b_stall, b_done} !== 3'b110) begin
                n_err++; $display("FAIL drain_hold cyc=%0d got req/stall/done=%b want 110", c, {b_req, b_stall, b_done});
            end
            @(negedge clk);
            flush_i = 1'b0;
            bus_ack_i = (c == 1);
        end
        bus_ack_i = 1'b0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_cmp++;
            if ({b_req, b_stall, b_done, b_ll} !== 4'b0000) begin
                n_err++; $display("FAIL drain_end cyc=%0d got req/stall/done/ll=%b want 0000", c, {b_req, b_stall, b_done, b_ll});
            end
            @(negedge clk);
        end
        op_valid_i = 1'b1; op_i = 4'd1; addr_i = 32'h0000_6200;
        @(negedge clk);
        op_valid_i = 1'b0; bus_ack_i = 1'b1; flush_i = 1'b1;
        @(negedge clk);
        bus_ack_i = 1'b0; flush_i = 1'b0;
        #1;
        n_cmp++;
        if ({b_req, b_stall, b_done} !== 3'b000) begin
            n_err++; $display("FAIL flush_ack got req/stall/done=%b want 000", {b_req, b_stall, b_done});
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_bus();
        xact(4'd9, 32'h0000_7000, 32'd0, 0, 32'd0);
        @(negedge clk);
        op_valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h0000_7004;
        @(negedge clk);
        #1;
        n_cmp++;
        if (b_req !== 1'b1) begin n_err++; $display("FAIL pre_reset_req got %b want 1", b_req); end
        #1;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({b_req, b_stall, b_done, b_ll, b_sel, b_addr, b_rdata, b_exc} !== '0) begin
            n_err++; $display("FAIL async_reset got req=%b stall=%b done=%b ll=%b sel=%b want all 0", b_req, b_stall, b_done, b_ll, b_sel);
        end
        @(negedge clk);
        op_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        m_ll = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] addr;
        for (int i = 0; i < 80; i++) begin
            op   = 4'($urandom_range(1, 10));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (op inside {3, 4, 7}) addr[0] = 1'b0;
                if (op inside {5, 8, 9, 10}) addr[1:0] = 2'b00;
            end
            xact(op, addr, $urandom, $urandom_range(0, TO), $urandom);
            case ($urandom_range(0, 3))
                0:       pulse_llclr();
                1:       idle_cycle();
                default: ;
            endcase
        end
        idle_cycle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_lb_be();
        test_store_lanes();
        test_misaligned();
        test_llsc();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_reset_mid_bus();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
